// File: rtl/credit_pkg.sv
// Shared types and the round-robin pick helper for the credit scheduler.
package credit_pkg;

    localparam int MAX_REQ     = 16;
    localparam int NUM_REQ_DEF = 4;
    localparam int IDX_W       = $clog2(NUM_REQ_DEF);

    typedef enum logic {INIT, RUN} state_t;

    // Returns {found, idx}: first set bit at or after ptr, wrapping at n-1.
    function automatic logic [4:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [3:0]         ptr,
        input int                 n
    );
        logic [4:0] r;
        int         k;
        r = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < n) begin
                k = (int'(ptr) + i) % n;
                if (valid[4'(k)]) r = {1'b1, 4'(k)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/credit_rr_scheduler_if.sv
// Upstream request/data, downstream link and credit signals of the scheduler.
interface credit_rr_scheduler_if #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int CREDIT_WIDTH = 8
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            i_req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
    logic [NUM_REQ-1:0]            o_req_read;
    logic [DATA_WIDTH-1:0]         o_data;
    logic                          o_valid;
    logic [IW-1:0]                 o_grant_idx;
    logic                          i_increment_count;
    logic [CREDIT_WIDTH-1:0]       o_credits;
    logic                          o_credit_error;

    modport master (
        output i_req_valid, i_req_data, i_increment_count,
        input  o_req_read, o_data, o_valid, o_grant_idx,
        input  o_credits, o_credit_error
    );

    modport slave (
        input  i_req_valid, i_req_data, i_increment_count,
        output o_req_read, o_data, o_valid, o_grant_idx,
        output o_credits, o_credit_error
    );

endinterface

// File: rtl/credit_rr_scheduler_counter.sv
// Saturating credit pool with sticky overflow flag.
module credit_counter #(
    parameter int MAX_CREDITS  = 8,
    parameter int CREDIT_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    dec,
    input  logic                    inc,
    output logic [CREDIT_WIDTH-1:0] count,
    output logic                    nonzero,
    output logic                    overflow
);

    localparam logic [CREDIT_WIDTH-1:0] FULL = CREDIT_WIDTH'(MAX_CREDITS);

    assign nonzero = (count != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= FULL;
            overflow <= 1'b0;
        end else if (inc && !dec) begin
            if (count == FULL) overflow <= 1'b1;
            else               count    <= count + CREDIT_WIDTH'(1);
        end else if (dec && !inc) begin
            count <= count - CREDIT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/credit_rr_scheduler.sv
// Round-robin arbiter sharing one credit-controlled link among NUM_REQ FIFOs.
module credit_rr_scheduler
    import credit_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQ_DEF,
    parameter int DATA_WIDTH   = 16,
    parameter int MAX_CREDITS  = 8,
    parameter int CREDIT_WIDTH = 8
) (
    input logic                   clock,
    input logic                   reset,
    credit_rr_scheduler_if.slave  bus
);

    localparam int IW = $clog2(NUM_REQ);

    state_t                 state, state_n;
    logic [IW-1:0]          rr_ptr, ptr_n, g, gidx_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   valid_q, fire, found, nonzero;
    logic [3:0]             pick_idx;
    logic [MAX_REQ-1:0]     vext;
    logic [3:0]             pext;
    logic [NUM_REQ-1:0]     rd;

    always_comb begin
        vext = '0;
        vext[NUM_REQ-1:0] = bus.i_req_valid;
        pext = '0;
        pext[IW-1:0] = rr_ptr;
        {found, pick_idx} = rr_pick(vext, pext, NUM_REQ);
        g = IW'(pick_idx);
        ptr_n = (g == IW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
    end

    // INIT holds off grants for exactly one cycle after reset.
    always_comb begin
        state_n = state;
        fire    = 1'b0;
        rd      = '0;
        unique case (state)
            INIT:    state_n = RUN;
            RUN:     fire = nonzero && found && !reset;
            default: state_n = INIT;
        endcase
        if (fire) rd[g] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= INIT;
        else       state <= state_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            gidx_q  <= '0;
        end else begin
            valid_q <= fire;
            if (fire) begin
                rr_ptr <= ptr_n;
                data_q <= bus.i_req_data[g*DATA_WIDTH +: DATA_WIDTH];
                gidx_q <= g;
            end
        end
    end

    credit_counter #(
        .MAX_CREDITS  (MAX_CREDITS),
        .CREDIT_WIDTH (CREDIT_WIDTH)
    ) u_credit_counter (
        .clock    (clock),
        .reset    (reset),
        .dec      (fire),
        .inc      (bus.i_increment_count),
        .count    (bus.o_credits),
        .nonzero  (nonzero),
        .overflow (bus.o_credit_error)
    );

    assign bus.o_req_read  = rd;
    assign bus.o_data      = data_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_grant_idx = gidx_q;

endmodule

// File: tb/tb_credit_rr_scheduler.sv
// Directed and random checks of credit_rr_scheduler against a reference model.
module tb_credit_rr_scheduler;

    localparam int NR   = 4;
    localparam int DW   = 16;
    localparam int CW   = 8;
    localparam int MAXC = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    credit_rr_scheduler_if #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .CREDIT_WIDTH(CW)
    ) bus ();

    credit_rr_scheduler #(
        .NUM_REQ(NR), .DATA_WIDTH(DW),
        .MAX_CREDITS(MAXC), .CREDIT_WIDTH(CW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    int          m_credits, m_ptr, m_gidx;
    logic [DW-1:0] m_data;
    bit          m_valid, m_err, m_quiet;
    logic [DW-1:0] head [NR];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_credits = MAXC;
        m_ptr     = 0;
        m_gidx    = 0;
        m_data    = '0;
        m_valid   = 1'b0;
        m_err     = 1'b0;
        m_quiet   = 1'b1;
    endtask

    // One clock: drive, check mid-cycle, then advance the model on the edge.
    task automatic step(input bit rst, input logic [NR-1:0] v, input bit inc);
        int            g;
        bit            fire;
        logic [NR-1:0] exp_rd;
        reset = rst;
        bus.i_req_valid = v;
        bus.i_increment_count = inc;
        for (int k = 0; k < NR; k++) bus.i_req_data[k*DW +: DW] = head[k];
        g = -1;
        for (int i = 0; i < NR; i++)
            if (g < 0 && v[(m_ptr + i) % NR]) g = (m_ptr + i) % NR;
        fire = !rst && !m_quiet && m_credits > 0 && g >= 0;
        exp_rd = '0;
        if (fire) exp_rd[g] = 1'b1;
        @(negedge clock);
        check("req_read", 32'(bus.o_req_read), 32'(exp_rd));
        check("valid", 32'(bus.o_valid), 32'(m_valid));
        check("data", 32'(bus.o_data), 32'(m_data));
        check("grant_idx", 32'(bus.o_grant_idx), 32'(m_gidx));
        check("credits", 32'(bus.o_credits), 32'(m_credits));
        check("credit_error", 32'(bus.o_credit_error), 32'(m_err));
        @(posedge clock);
        if (rst) begin
            model_reset();
        end else begin
            if (fire) begin
                m_data  = head[g];
                m_valid = 1'b1;
                m_gidx  = g;
                m_ptr   = (g + 1) % NR;
                head[g] = head[g] + 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (inc && !fire && m_credits == MAXC) m_err = 1'b1;
            else m_credits = m_credits - int'(fire) + int'(inc);
            m_quiet = 1'b0;
        end
        #1;
    endtask

    initial begin
        bus.i_req_valid = '0;
        bus.i_req_data = '0;
        bus.i_increment_count = 1'b0;
        for (int k = 0; k < NR; k++) head[k] = DW'(16'h1000 * (k + 1));
        reset = 1'b1;
        @(posedge clock);
        #1;
        model_reset();

        // reset then idle
        step(1'b1, 4'b0000, 1'b0);
        repeat (10) step(1'b0, 4'b0000, 1'b0);
        check("idle_credits", 32'(bus.o_credits), 32'd8);

        // single requester 2 drains the pool
        head[2] = 16'h00A0;
        step(1'b1, 4'b0000, 1'b0);
        repeat (12) step(1'b0, 4'b0100, 1'b0);
        check("drain_credits", 32'(bus.o_credits), 32'd0);
        check("last_word", 32'(bus.o_data), 32'h00A7);

        // all valid with a return every cycle
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b1111, 1'b0);
        repeat (12) step(1'b0, 4'b1111, 1'b1);
        check("steady_credits", 32'(bus.o_credits), 32'd8);

        // returned credit usable only from the next cycle
        step(1'b1, 4'b0000, 1'b0);
        repeat (9) step(1'b0, 4'b0010, 1'b0);
        step(1'b0, 4'b0010, 1'b1);
        step(1'b0, 4'b0010, 1'b0);
        check("return_credits", 32'(bus.o_credits), 32'd0);

        // overflow is sticky until reset
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        repeat (4) step(1'b0, 4'b0000, 1'b0);
        check("err_sticky", 32'(bus.o_credit_error), 32'd1);
        step(1'b1, 4'b0000, 1'b0);
        check("err_cleared", 32'(bus.o_credit_error), 32'd0);

        // reset mid-stream
        repeat (6) step(1'b0, 4'b1001, 1'b0);
        check("mid_credits", 32'(bus.o_credits), 32'd3);
        step(1'b1, 4'b1001, 1'b0);
        check("mid_valid", 32'(bus.o_valid), 32'd0);
        check("mid_reload", 32'(bus.o_credits), 32'd8);
        step(1'b0, 4'b1001, 1'b0);
        step(1'b0, 4'b1001, 1'b0);
        check("post_grant", 32'(bus.o_grant_idx), 32'd0);
        check("post_valid", 32'(bus.o_valid), 32'd1);

        // random traffic
        for (int k = 0; k < NR; k++) head[k] = DW'($urandom);
        repeat (400) begin
            step($urandom_range(0, 49) == 0, NR'($urandom),
                 $urandom_range(0, 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/credit_rr_scheduler.md
Name: credit_rr_scheduler

Overview:
- Shares one credit-controlled downstream link among NUM_REQ upstream show-ahead FIFOs.
- Holds the shared credit pool for the link. Grants one requester per cycle in round-robin order while credits remain. Registers the selected word onto the link.
- Credits come back one per cycle through a pulse from the downstream FIFO read logic, which pulses once per word it dequeues.
- Sits between the producer-side FIFOs and the relay/FIFO stage in front of the FIR datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 16, payload bits per word.
- MAX_CREDITS, 8, downstream FIFO depth; reset value of the credit pool (1..255).
- CREDIT_WIDTH, 8, counter width; must hold MAX_CREDITS.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_req_valid  in  NUM_REQ  bit k = requester k FIFO non-empty (show-ahead head word valid).
- i_req_data  in  NUM_REQ*DATA_WIDTH  head words; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_req_read  out  NUM_REQ  one-hot read request (pop) to the granted requester FIFO; combinational.
- o_data  out  DATA_WIDTH  registered word to the downstream FIFO.
- o_valid  out  1  registered write-enable to the downstream FIFO.
- o_grant_idx  out  $clog2(NUM_REQ)  registered index of the requester that sourced o_data.
- i_increment_count  in  1  credit-return pulse, one credit per cycle high.
- o_credits  out  CREDIT_WIDTH  current credit count.
- o_credit_error  out  1  sticky; set on credit-return overflow.

Behaviour:
- Reset state, applied on the edge where reset is sampled high:
  - credits = MAX_CREDITS, rr_ptr = 0.
  - o_valid = 0, o_data = 0, o_grant_idx = 0, o_credit_error = 0.
- During reset, o_req_read = 0 and i_increment_count is ignored.
- Eligibility: fire = (credits != 0) && |i_req_valid && !reset.
  - No same-cycle bypass: a credit returned in cycle t is usable from cycle t+1.
- Arbitration, round-robin:
  - Search i_req_valid starting at index rr_ptr and wrapping at NUM_REQ-1 -> 0. First set bit wins (index g).
  - On fire: o_req_read = one-hot(g) and rr_ptr <= (g+1) mod NUM_REQ.
  - No fire: rr_ptr holds and o_req_read = 0.
- Output register, latency 1:
  - On fire: o_data <= i_req_data slice g, o_valid <= 1, o_grant_idx <= g.
  - Otherwise: o_valid <= 0; o_data and o_grant_idx hold.
- Credit update: credits <= credits - fire + i_increment_count.
  - Simultaneous fire and return: count unchanged.
  - Credits never go below 0; guaranteed by the fire condition.
  - If credits == MAX_CREDITS and a return arrives with no fire: credits stay MAX_CREDITS (saturate) and o_credit_error <= 1 until reset.
- Throughput: one word per cycle while credits > 0 and any request is valid.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 grants.
- Reset mid-stream:
  - The in-flight o_valid drops on the next edge.
  - The credit pool reloads to MAX_CREDITS. The downstream FIFO must be reset in the same cycle.
- Arbitration and pointer update are implemented as a two-state FSM:
  - INIT: entered on reset. Outputs are quiet. Moves to RUN on the first cycle after reset deasserts.
  - RUN: normal operation.
  - The INIT cycle guarantees no grant in the first post-reset cycle.

Decomposition:
- Package credit_pkg holds:
  - the localparam for the index width, computed from NUM_REQ;
  - typedef state_t {INIT, RUN};
  - a function rr_pick(valid, ptr) returning {found, idx}.
- One natural sub-module, credit_counter (parameters MAX_CREDITS, CREDIT_WIDTH). Ports: dec, inc, count, nonzero, overflow. It is reusable by the other LID relay stations.

Test Plan:
- Reset, then idle: o_credits = 8 and o_valid = 0 after reset. With all i_req_valid = 0 for 10 cycles there are no reads and credits stay 8.
- Single requester 2 always valid with data 0x00A0+n, no returns:
  - exactly 8 reads, then o_req_read stays 0;
  - o_data sequence 0x00A0..0x00A7, each one cycle after its read;
  - o_credits = 0.
- All 4 requesters valid, i_increment_count held 1 every cycle, credits at 8: grants go 0,1,2,3,0,... at one per cycle and o_credits stays 8.
- Credits = 0 with a return pulse in cycle t and requester 1 valid: the grant is asserted in cycle t+1, not t, and o_credits returns to 0 in cycle t+2.
- Credits = 8, i_increment_count = 1, no requests: o_credits stays 8 and o_credit_error = 1 from the next cycle, persisting until reset.
- Reset asserted while requesters 0 and 3 are streaming with credits = 3:
  - next cycle: o_valid = 0, o_req_read = 0, o_credits = 8, o_credit_error = 0;
  - first grant goes to requester 0, two cycles after reset deasserts.
